// File: rtl/enc_pkg.sv
//------------------------------------------------------------------------------
// Module   : enc_pkg
// Purpose  : Shared types and constants for the enc4to2 priority encoder.
//            Holds the output-register state enum and the index, request and
//            error-counter widths with the error-counter saturation value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package enc_pkg;

  localparam int IDX_W = 2;  // width of the encoded index A
  localparam int REQ_W = 4;  // width of the request vector D
  localparam int ERR_W = 8;  // width of err_cnt

  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  // Output register occupancy: EMPTY means nothing held for the consumer.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : enc_pkg

`default_nettype wire

// File: rtl/enc4to2_pri.sv
//------------------------------------------------------------------------------
// Module   : enc4to2_pri
// Purpose  : Purely combinational priority pick over a 4-bit request vector.
//            The search starts at index 'start' and walks downward
//            (dir_down=1) or upward (dir_down=0), wrapping modulo 4.
// Ports    : r        in  [3:0] effective request (already masked by enable)
//            start    in  [1:0] highest-priority index
//            dir_down in        search direction
//            a        out [1:0] index of first set bit found (0 when r==0)
//            v        out       any bit of r set
//            m        out       two or more bits of r set
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enc4to2_pri
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0] r,
  input  logic [IDX_W-1:0] start,
  input  logic             dir_down,
  output logic [IDX_W-1:0] a,
  output logic             v,
  output logic             m
);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] step;
  logic             found;
  logic [2:0]       ones;

  always_comb begin
    a     = '0;
    found = 1'b0;
    idx   = '0;
    step  = '0;
    for (int i = 0; i < REQ_W; i++) begin
      step = i[IDX_W-1:0];
      // 2-bit arithmetic gives the modulo-4 wrap for free.
      idx  = dir_down ? (start - step) : (start + step);
      if (!found && r[idx]) begin
        a     = idx;
        found = 1'b1;
      end
    end
  end

  assign ones = {2'b00, r[0]} + {2'b00, r[1]} + {2'b00, r[2]} + {2'b00, r[3]};
  assign v    = |r;
  assign m    = (ones >= 3'd2);

endmodule : enc4to2_pri

`default_nettype wire

// File: rtl/enc4to2.sv
//------------------------------------------------------------------------------
// Module   : enc4to2
// Purpose  : Registered 4-to-2 priority encoder with a valid/ready handshake
//            on both sides, a one-entry output register and a saturating
//            count of multi-hot requests.
//            Build option ENC4TO2_RR_EN: round-robin priority (pointer moves
//            past each grant) replaces the fixed HI_FIRST priority.
// Ports    : clk, rst            clock, synchronous active-high reset
//            E, D, in_valid      enable, request vector, input valid
//            in_ready            accept indication (= ~out_valid | out_ready)
//            A, V, M, out_valid  registered result and its valid
//            out_ready           consumer takes the result
//            err_cnt             saturating count of accepted multi-hot inputs
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enc4to2
  import enc_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [REQ_W-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] A,
  output logic             V,
  output logic             M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_cnt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] a_q, a_d;
  logic             v_q, v_d;
  logic             m_q, m_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [REQ_W-1:0] w_req;
  logic [IDX_W-1:0] w_start;
  logic             w_dir_down;
  logic [IDX_W-1:0] w_a;
  logic             w_v;
  logic             w_m;
  logic             w_xfer_in;
  logic             w_xfer_out;

  assign out_valid  = (state_q == FULL);
  assign in_ready   = ~out_valid | out_ready;
  assign w_xfer_in  = in_valid & in_ready;
  assign w_xfer_out = out_valid & out_ready;
  assign w_req      = D & {REQ_W{E}};

`ifdef ENC4TO2_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign w_start    = ptr_q;
  assign w_dir_down = 1'b0;

  // Pointer moves one past the granted index so that request gets lowest
  // priority next time; an empty request leaves it where it is.
  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer_in && w_v) begin
      ptr_d = w_a + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // HI_FIRST=1: walk 3,2,1,0; HI_FIRST=0: walk 0,1,2,3.
  assign w_start    = (HI_FIRST != 0) ? 2'd3 : 2'd0;
  assign w_dir_down = (HI_FIRST != 0);
`endif

  enc4to2_pri u_pri (
    .r        (w_req),
    .start    (w_start),
    .dir_down (w_dir_down),
    .a        (w_a),
    .v        (w_v),
    .m        (w_m)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    v_d       = v_q;
    m_d       = m_q;
    err_cnt_d = err_cnt_q;
    if (w_xfer_in) begin
      // Covers both EMPTY->FULL and the FULL->FULL reload.
      state_d = FULL;
      a_d     = w_a;
      v_d     = w_v;
      m_d     = w_m;
      if (w_m && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (w_xfer_out) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      a_q       <= '0;
      v_q       <= 1'b0;
      m_q       <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      v_q       <= v_d;
      m_q       <= m_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign A       = a_q;
  assign V       = v_q;
  assign M       = m_q;
  assign err_cnt = err_cnt_q;

endmodule : enc4to2

`default_nettype wire
